openhw_cache_line_xfer: RTL

OPENHW_CACHE_LINE_XFER -- requirements
Module: openhw_cache_line_xfer

---
 rtl/openhw_cache_line_xfer.sv | 106 ++++++++++
 1 files changed

// File: rtl/openhw_cache_line_xfer.sv
// openhw_cache_line_xfer
//   Moves one cache line between a cache and a narrow bus, one beat at a
//   time. Fetches assemble the incoming beats in FetchBuffer. Writebacks
//   slice WritebackLine into beats.
//
// Ports
//   clk, reset     : single clock, asynchronous active-high reset
//   FlushStage     : blocks starting a new transfer (an active one is not aborted)
//   CacheBusRW     : [1] fetch request, [0] writeback request (writeback wins)
//   CacheBusAdr    : line address; offset bits ignored
//   WritebackLine  : line to write back, held stable by the cache
//   CacheBusAck    : one-cycle pulse when the whole line has moved
//   FetchBuffer    : assembled fetched line
//   BusReq/BusWrite/BusAdr/BusWData : beat request toward the bus
//   BusReady/BusRData               : beat completion and read data
module openhw_cache_line_xfer #(
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    parameter int PA_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [LINELEN-1:0] WritebackLine,
    output logic               CacheBusAck,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               BusReq,
    output logic               BusWrite,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWData,
    input  logic               BusReady,
    input  logic [BEATLEN-1:0] BusRData
);

    localparam int BEATS    = LINELEN / BEATLEN;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BEAT_OFS = $clog2(BEATLEN / 8);

    // Byte offset within a line; these address bits are cleared on latch.
    localparam logic [PA_BITS-1:0] LINE_MASK = PA_BITS'(LINELEN / 8 - 1);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   beat_count;
    logic               dir_write;   // latched direction: 1 = writeback
    logic [PA_BITS-1:0] line_adr;

    logic start;
    logic beat_done;

    assign start     = (state == S_IDLE) && !FlushStage && (CacheBusRW != 2'b00);
    assign beat_done = (state == S_XFER) && BusReady;

    // Handshake outputs depend only on registered state so that the cache
    // request never reaches the bus combinationally.
    assign BusReq      = (state == S_XFER);
    assign BusWrite    = (state == S_XFER) && dir_write;
    assign CacheBusAck = (state == S_DONE);

    assign BusAdr   = line_adr | (PA_BITS'(beat_count) << BEAT_OFS);
    assign BusWData = WritebackLine[beat_count*BEATLEN +: BEATLEN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            beat_count  <= '0;
            dir_write   <= 1'b0;
            line_adr    <= '0;
            FetchBuffer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Bit 0 selects writeback, so it wins when both are set.
                        dir_write  <= CacheBusRW[0];
                        line_adr   <= CacheBusAdr & ~LINE_MASK;
                        beat_count <= '0;
                        state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat_done) begin
                        if (!dir_write)
                            FetchBuffer[beat_count*BEATLEN +: BEATLEN] <= BusRData;
                        if (beat_count == LAST_BEAT) begin
                            beat_count <= '0;
                            state      <= S_DONE;
                        end else begin
                            beat_count <= beat_count + 1'b1;
                        end
                    end
                end
                // Requests seen during the ack cycle wait for the next IDLE.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
